// File: rtl/note_player_if.sv
// Note/sample bus between the song reader, the note player and the codec.
// master: song reader / timing side; slave: note_player.
interface note_player_if;
  logic               play_enable;
  logic               new_note;
  logic        [5:0]  note;
  logic        [5:0]  duration;
  logic               beat;
  logic               sample_tick;
  logic               note_done;
  logic signed [15:0] sample_out;
  logic               sample_valid;

  modport master (
    output play_enable, new_note, note, duration, beat, sample_tick,
    input  note_done, sample_out, sample_valid
  );

  modport slave (
    input  play_enable, new_note, note, duration, beat, sample_tick,
    output note_done, sample_out, sample_valid
  );
endinterface

// File: rtl/note_player.sv
// Square-wave note synthesiser: latches a note, emits +/-AMP samples at the
// pitch's half-period, counts beats and pulses note_done when the note ends.
module note_player #(
  parameter logic signed [15:0] AMP = 16'sd8192
) (
  input logic          clk,
  input logic          reset,
  note_player_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StPlaying, StDone} state_e;

  state_e             r_state;
  logic        [5:0]  r_note;
  logic        [5:0]  r_dur;
  logic        [5:0]  r_beat_cnt;
  logic        [8:0]  r_hp_cnt;
  logic               r_pol;
  logic               r_note_done;
  logic signed [15:0] r_sample;
  logic               r_sample_valid;

  logic        [5:0]  w_nm1;
  logic        [2:0]  w_oct;
  logic        [3:0]  w_semi;
  logic        [8:0]  w_base;
  logic        [8:0]  w_hp;
  logic        [5:0]  w_eff_dur;
  logic               w_last_beat;
  logic               w_hp_wrap;

  // Pitch decode: half-period in samples from the latched note index.
  always_comb begin
    w_nm1  = r_note - 6'd1;
    w_oct  = 3'(w_nm1 / 6'd12);
    w_semi = 4'(w_nm1 % 6'd12);
    w_base = 9'd436;
    unique case (w_semi)
      4'd0:    w_base = 9'd436;
      4'd1:    w_base = 9'd412;
      4'd2:    w_base = 9'd389;
      4'd3:    w_base = 9'd367;
      4'd4:    w_base = 9'd346;
      4'd5:    w_base = 9'd327;
      4'd6:    w_base = 9'd309;
      4'd7:    w_base = 9'd291;
      4'd8:    w_base = 9'd275;
      4'd9:    w_base = 9'd259;
      4'd10:   w_base = 9'd245;
      4'd11:   w_base = 9'd231;
      default: w_base = 9'd436;
    endcase
    w_hp = w_base >> w_oct;
  end

  // Beat-end and half-period-end detection; a zero duration counts as one beat.
  always_comb begin
    w_eff_dur   = (r_dur == 6'd0) ? 6'd1 : r_dur;
    w_last_beat = ({1'b0, r_beat_cnt} + 7'd1) == {1'b0, w_eff_dur};
    w_hp_wrap   = r_hp_cnt == (w_hp - 9'd1);
  end

  // Control FSM with registered outputs; new_note overrides everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_note         <= 6'd0;
      r_dur          <= 6'd0;
      r_beat_cnt     <= 6'd0;
      r_hp_cnt       <= 9'd0;
      r_pol          <= 1'b1;
      r_note_done    <= 1'b0;
      r_sample       <= 16'sd0;
      r_sample_valid <= 1'b0;
    end else begin
      r_note_done    <= 1'b0;
      r_sample_valid <= io_bus.sample_tick;
      if (io_bus.new_note) begin
        r_state    <= StPlaying;
        r_note     <= io_bus.note;
        r_dur      <= io_bus.duration;
        r_beat_cnt <= 6'd0;
        r_hp_cnt   <= 9'd0;
        r_pol      <= 1'b1;
        r_sample   <= 16'sd0;
      end else begin
        unique case (r_state)
          StIdle: r_sample <= 16'sd0;
          StPlaying: begin
            if (!io_bus.play_enable) begin
              // Paused: counters and polarity hold, output silent.
              r_sample <= 16'sd0;
            end else if (io_bus.beat && w_last_beat) begin
              r_state     <= StDone;
              r_note_done <= 1'b1;
              r_sample    <= 16'sd0;
            end else begin
              if (io_bus.beat) r_beat_cnt <= r_beat_cnt + 6'd1;
              if (io_bus.sample_tick) begin
                if (w_hp_wrap) begin
                  r_hp_cnt <= 9'd0;
                  r_pol    <= ~r_pol;
                end else begin
                  r_hp_cnt <= r_hp_cnt + 9'd1;
                end
                // Sample reflects the polarity before this tick's toggle.
                if (r_note == 6'd0) r_sample <= 16'sd0;
                else                r_sample <= r_pol ? AMP : -AMP;
              end
            end
          end
          StDone: begin
            r_state  <= StIdle;
            r_sample <= 16'sd0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_bus.note_done    = r_note_done;
  assign io_bus.sample_out   = r_sample;
  assign io_bus.sample_valid = r_sample_valid;

endmodule
